// File: rtl/alu_shift_pkg.sv
// Shared definitions for the pipelined ALU barrel shifter: op encodings and
// helpers that spread the log2(WIDTH) shift levels across the pipeline stages.
package alu_shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // First level owned by stage k: smallest l with floor(l*stages/sw) >= k.
    function automatic int unsigned stage_lo(input int unsigned k, input int unsigned stages,
                                             input int unsigned sw);
        return (k * sw + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// One pipeline slot of the barrel shifter: applies levels LO_LEVEL..HI_LEVEL and
// registers the result. ALU_SHIFT_ROR_EN enables rotate-right for op 2'b10.
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LO_LEVEL = 0,
    parameter int unsigned HI_LEVEL = 0,
    localparam int unsigned SW      = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [SW-1:0]    in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_op,
    output logic [SW-1:0]    out_shamt
);
    localparam int unsigned NLVL = HI_LEVEL - LO_LEVEL + 1;

    shift_op_e                  op;
    logic                       advance;
    logic [NLVL:0][WIDTH-1:0]   lvl;
    logic                       valid_q;
    logic [WIDTH-1:0]           data_q;
    logic [1:0]                 op_q;
    logic [SW-1:0]              shamt_q;

    function automatic logic [WIDTH-1:0] apply(input logic [WIDTH-1:0] d, input shift_op_e o,
                                               input int unsigned amt);
        logic [WIDTH-1:0] r;
        r = '0;
        unique case (o)
            OP_SLL: r = d << amt;
            OP_SRL: r = d >> amt;
            OP_SRA: r = $signed(d) >>> amt;
`ifdef ALU_SHIFT_ROR_EN
            OP_ROR: r = (d >> amt) | (d << (WIDTH - amt));
`else
            OP_ROR: r = '0;
`endif
        endcase
        return r;
    endfunction

    assign op       = shift_op_e'(in_op);
    assign advance  = !valid_q || out_ready;
    assign in_ready = advance;

`ifdef ALU_SHIFT_ROR_EN
    assign lvl[0] = in_data;
`else
    // Without rotate support op 10 must read zero even when no level fires.
    assign lvl[0] = (op == OP_ROR) ? '0 : in_data;
`endif

    for (genvar g = 0; g < NLVL; g++) begin : g_level
        assign lvl[g+1] = in_shamt[LO_LEVEL+g] ? apply(lvl[g], op, 1 << (LO_LEVEL + g)) : lvl[g];
    end

    // Data only loads on a real transfer so out_data holds across flush and bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= OP_SLL;
            shamt_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q  <= lvl[NLVL];
                op_q    <= in_op;
                shamt_q <= in_shamt;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;
    assign out_shamt = shamt_q;

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter for the ALU shift path: STAGES valid/ready slots with flush.
// Rotate support for op 2'b10 is enabled by defining ALU_SHIFT_ROR_EN.
module alu_shift_pipe
    import alu_shift_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int unsigned SW = clog2(WIDTH);

    logic [STAGES:0]            valid;
    logic [STAGES:0]            ready;
    logic [STAGES:0][WIDTH-1:0] data;
    logic [STAGES:0][1:0]       op;
    logic [STAGES:0][SW-1:0]    shamt;
    logic                       unused_bits;

    assign valid[0]      = in_valid;
    assign data[0]       = in_b;
    assign op[0]         = in_op;
    assign shamt[0]      = in_a[SW-1:0];
    assign ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        alu_shift_stage #(
            .WIDTH    (WIDTH),
            .LO_LEVEL (stage_lo(k, STAGES, SW)),
            .HI_LEVEL (stage_lo(k + 1, STAGES, SW) - 1)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (valid[k]),
            .in_ready  (ready[k]),
            .in_data   (data[k]),
            .in_op     (op[k]),
            .in_shamt  (shamt[k]),
            .out_valid (valid[k+1]),
            .out_ready (ready[k+1]),
            .out_data  (data[k+1]),
            .out_op    (op[k+1]),
            .out_shamt (shamt[k+1])
        );
    end

    assign in_ready  = !reset && !flush && ready[0];
    assign out_valid = valid[STAGES];
    assign out_data  = data[STAGES];

    // Shift amount is modulo WIDTH; the final slot's op/shamt have no consumer.
    assign unused_bits = ^{in_a[WIDTH-1:SW], op[STAGES], shamt[STAGES]};

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Self-checking bench for alu_shift_pipe: directed cases on STAGES=2 plus randomized
// traffic on STAGES=1..5 against a queue-based reference model.
module tb_alu_shift_pipe;
    localparam int unsigned W  = 32;
    localparam int          NI = 5;

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [W-1:0] in_a, in_b;
    logic [1:0]   in_op;
    logic [NI:1]          in_ready_w;
    logic [NI:1]          out_valid_w;
    logic [NI:1][W-1:0]   out_data_w;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= NI; g++) begin : g_dut
        alu_shift_pipe #(
            .WIDTH  (W),
            .STAGES (g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_op     (in_op),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [W-1:0] exp_q[$];
    bit           hold_pending = 1'b0;
    logic [W-1:0] hold_data;
    bit           acc;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
        int unsigned  sh;
        logic [W-1:0] r;
        sh = a % W;
        case (op)
            2'b00:   r = b << sh;
            2'b01:   r = b >> sh;
            2'b11:   r = b[W-1] ? ~((~b) >> sh) : (b >> sh);
`ifdef ALU_SHIFT_ROR_EN
            default: r = (b >> sh) | (b << (W - sh));
`else
            default: r = '0;
`endif
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(input int s, output bit accepted);
        #1;
        if (hold_pending) begin
            check("hold_valid", W'(out_valid_w[s]), 1);
            check("hold_data", out_data_w[s], hold_data);
        end
        if (out_valid_w[s] && out_ready) begin
            n_out++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL spurious_out: observed %h, expected no output", out_data_w[s]);
            end
            if (exp_q.size() > 0) check("fifo_data", out_data_w[s], exp_q.pop_front());
        end
        hold_pending = out_valid_w[s] && !out_ready;
        hold_data    = out_data_w[s];
        accepted     = in_valid && in_ready_w[s];
        if (accepted) exp_q.push_back(ref_shift(in_a, in_b, in_op));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
    endtask

    // Single op with an idle pipe: out_valid must rise exactly s cycles after accept.
    task automatic run_one(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [W-1:0] exp, input string tag);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, W'(in_ready_w[s]), 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= s; c++) begin
            #1;
            check({tag, "_out_valid"}, W'(out_valid_w[s]), W'(c == s));
            if (c == s) check({tag, "_data"}, out_data_w[s], exp);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int issued;
        bit saw_low;
        logic [W-1:0] a_res;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = 2'b00;
        #1;
        check("reset_in_ready", W'(in_ready_w[2]), 0);
        @(negedge clk);
        #1;
        for (int s = 1; s <= NI; s++) begin
            check("reset_out_valid", W'(out_valid_w[s]), 0);
            check("reset_out_data", out_data_w[s], 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed shifts on the STAGES=2 instance.
        run_one(2, 32'd99, 32'hFFFFB57B, 2'b11, 32'hFFFFF6AF, "sra_neg");
        run_one(2, 32'd31, 32'd1, 2'b00, 32'h80000000, "sll_31");
        run_one(2, 32'd4, 32'h80000000, 2'b01, 32'h08000000, "srl_4");
        run_one(2, 32'd32, 32'd5, 2'b00, 32'd5, "sll_mod");
        run_one(2, 32'd32, 32'd5, 2'b01, 32'd5, "srl_mod");
        run_one(2, 32'd32, 32'd5, 2'b11, 32'd5, "sra_mod");
`ifdef ALU_SHIFT_ROR_EN
        run_one(2, 32'd32, 32'd5, 2'b10, 32'd5, "ror_mod");
        run_one(2, 32'd1, 32'd1, 2'b10, 32'h80000000, "ror_1");
`else
        run_one(2, 32'd1, 32'd1, 2'b10, 32'h00000000, "ror_off");
`endif

        // Backpressure: six back-to-back ops, consumer stalls cycles 2-5.
        exp_q.delete(); n_out = 0; issued = 0; saw_low = 1'b0; hold_pending = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (issued == 6 && exp_q.size() == 0) break;
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (issued < 6);
            in_a      = $urandom;
            in_b      = $urandom;
            in_op     = 2'($urandom_range(3));
            tick(2, acc);
            if (acc) issued++;
            if (in_valid && !acc) saw_low = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_in_ready_dropped", W'(saw_low), 1);
        check("bp_outputs", W'(n_out), 6);
        check("bp_left_over", W'(exp_q.size()), 0);

        // Flush with two ops in flight and a third offered in the flush cycle.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            in_op    = 2'($urandom_range(3));
            tick(2, acc);
        end
        a_res    = exp_q[0];
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", W'(in_ready_w[2]), 0);
        check("flush_pre_valid", W'(out_valid_w[2]), 1);
        check("flush_pre_data", out_data_w[2], a_res);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", W'(out_valid_w[2]), 0);
        check("flush_data_hold", out_data_w[2], a_res);
        exp_q.delete(); hold_pending = 1'b0;
        @(negedge clk);
        #1;
        check("flush_no_ghost", W'(out_valid_w[2]), 0);
        @(negedge clk);
        in_a = $urandom; in_b = $urandom; in_op = 2'($urandom_range(3));
        run_one(2, in_a, in_b, in_op, ref_shift(in_a, in_b, in_op), "post_flush");

        // Random traffic on each depth, with a reset in the middle of the stream.
        for (int s = 1; s <= NI; s++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                if (c == 120) begin
                    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
                    #1;
                    check("mid_rst_in_ready", W'(in_ready_w[s]), 0);
                    @(negedge clk);
                    reset = 1'b0; in_valid = 1'b0;
                    #1;
                    check("mid_rst_out_valid", W'(out_valid_w[s]), 0);
                    check("mid_rst_out_data", out_data_w[s], 0);
                    exp_q.delete(); hold_pending = 1'b0;
                    @(negedge clk);
                end
                in_valid  = ($urandom_range(9) < 7);
                out_ready = ($urandom_range(9) < 7);
                in_a      = $urandom;
                in_b      = $urandom;
                in_op     = 2'($urandom_range(3));
                tick(s, acc);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick(s, acc);
            check("drain_left_over", W'(exp_q.size()), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
